// File: rtl/fixed_latency_grant_sched_if.sv
// Handshake bundle between requesters and the fixed-latency grant scheduler.
// The id and in-flight count widths come from the requester count and the in-flight cap.
interface fixed_latency_grant_sched_if #(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned MAX_OUT = 2
);
   localparam int unsigned IDW = $clog2(NREQ);
   localparam int unsigned CW  = $clog2(MAX_OUT + 1);

   logic            en;
   logic [NREQ-1:0] req;
   logic [NREQ-1:0] ack;
   logic [NREQ-1:0] gnt;
   logic            gnt_vld;
   logic [IDW-1:0]  gnt_id;
   logic [CW-1:0]   out_cnt;
   logic            busy;

   modport master (
      output en, req,
      input  ack, gnt, gnt_vld, gnt_id, out_cnt, busy
   );

   modport slave (
      input  en, req,
      output ack, gnt, gnt_vld, gnt_id, out_cnt, busy
   );
endinterface

// File: rtl/fixed_latency_grant_sched.sv
// Round-robin scheduler: accepts at most one request per cycle and grants it
// exactly LAT cycles later, with at most MAX_OUT transactions in flight.
module fixed_latency_grant_sched #(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned LAT     = 2,
   parameter int unsigned MAX_OUT = 2
) (
   input logic                         clk,
   input logic                         rst,
   fixed_latency_grant_sched_if.slave  bus
);
   localparam int unsigned IDW = $clog2(NREQ);
   localparam int unsigned CW  = $clog2(MAX_OUT + 1);

   logic [IDW-1:0] ptr;
   logic [LAT-1:0] pv;
   logic [IDW-1:0] pid [LAT];
   logic [CW-1:0]  cnt;

   logic           retire;
   logic           slot;
   logic           found;
   logic           accept;
   logic [IDW-1:0] sel;
   logic [IDW-1:0] idx;

   // A grant retiring this cycle frees its slot for a same-cycle accept.
   always_comb begin
      retire = pv[LAT-1];
      slot   = (cnt < CW'(MAX_OUT)) || retire;
      found  = 1'b0;
      sel    = '0;
      idx    = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = IDW'((32'(ptr) + k) % NREQ);
         if (!found && bus.req[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
      accept = rst && bus.en && slot && found;
   end

   always_comb begin
      bus.ack = '0;
      if (accept) bus.ack[sel] = 1'b1;
   end

   always_comb begin
      bus.gnt = '0;
      if (pv[LAT-1]) bus.gnt[pid[LAT-1]] = 1'b1;
   end

   assign bus.gnt_vld = pv[LAT-1];
   assign bus.gnt_id  = pv[LAT-1] ? pid[LAT-1] : '0;
   assign bus.out_cnt = cnt;
   assign bus.busy    = (cnt != '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr <= '0;
         pv  <= '0;
         cnt <= '0;
         for (int unsigned k = 0; k < LAT; k++) pid[k] <= '0;
      end else begin
         pv[0]  <= accept;
         pid[0] <= sel;
         for (int unsigned k = 1; k < LAT; k++) begin
            pv[k]  <= pv[k-1];
            pid[k] <= pid[k-1];
         end
         if (accept) ptr <= IDW'((32'(sel) + 1) % NREQ);
         case ({accept, retire})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end
endmodule

// File: tb/tb_fixed_latency_grant_sched.sv
// Directed vector table plus multi-cycle sequences for the grant scheduler.
module tb_fixed_latency_grant_sched;
   logic clk;
   logic rst_a;
   logic rst_b;

   int checks;
   int errors;

   fixed_latency_grant_sched_if #(.NREQ(4), .MAX_OUT(2)) bus_a ();
   fixed_latency_grant_sched_if #(.NREQ(4), .MAX_OUT(1)) bus_b ();

   fixed_latency_grant_sched #(.NREQ(4), .LAT(2), .MAX_OUT(2)) dut_a (
      .clk (clk),
      .rst (rst_a),
      .bus (bus_a.slave)
   );

   fixed_latency_grant_sched #(.NREQ(4), .LAT(2), .MAX_OUT(1)) dut_b (
      .clk (clk),
      .rst (rst_b),
      .bus (bus_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       en;
      logic [3:0] req;
      logic [3:0] ack;
      logic [3:0] gnt;
      logic [1:0] gid;
      logic [1:0] cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic r, input logic e, input logic [3:0] rq,
                               input logic [3:0] a, input logic [3:0] g,
                               input logic [1:0] id, input logic [1:0] c);
      vec_t v;
      v.rst = r; v.en = e; v.req = rq; v.ack = a; v.gnt = g; v.gid = id; v.cnt = c;
      return v;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   logic [3:0] ack_d1;
   logic [3:0] ack_d2;
   logic [3:0] exp_gb [8];
   logic [3:0] exp_ab [8];

   initial begin
      checks = 0;
      errors = 0;
      rst_a = 1'b0;
      rst_b = 1'b0;
      bus_a.en = 1'b0; bus_a.req = '0;
      bus_b.en = 1'b0; bus_b.req = '0;

      //            rst  en  req      ack      gnt      id  cnt
      vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0));
      vecs.push_back(mk(1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0));
      // single request: ack now, grant two cycles later
      vecs.push_back(mk(1, 1, 4'b0100, 4'b0100, 4'b0000, 0, 0));
      vecs.push_back(mk(1, 1, 4'b0000, 4'b0000, 4'b0000, 0, 1));
      vecs.push_back(mk(1, 1, 4'b0000, 4'b0000, 4'b0100, 2, 1));
      vecs.push_back(mk(1, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0));
      // reset with requests pending: no ack while held
      vecs.push_back(mk(0, 1, 4'b1111, 4'b0000, 4'b0000, 0, 0));
      // all requesting, cap 2: full rotation
      vecs.push_back(mk(1, 1, 4'b1111, 4'b0001, 4'b0000, 0, 0));
      vecs.push_back(mk(1, 1, 4'b1111, 4'b0010, 4'b0000, 0, 1));
      vecs.push_back(mk(1, 1, 4'b1111, 4'b0100, 4'b0001, 0, 2));
      vecs.push_back(mk(1, 1, 4'b1111, 4'b1000, 4'b0010, 1, 2));
      vecs.push_back(mk(1, 1, 4'b1111, 4'b0001, 4'b0100, 2, 2));
      // en low: drain only
      vecs.push_back(mk(1, 0, 4'b1111, 4'b0000, 4'b1000, 3, 2));
      vecs.push_back(mk(1, 0, 4'b1111, 4'b0000, 4'b0001, 0, 1));
      vecs.push_back(mk(1, 0, 4'b1111, 4'b0000, 4'b0000, 0, 0));
      // requesters 0 and 2 alternate from ptr=1
      vecs.push_back(mk(1, 1, 4'b0101, 4'b0100, 4'b0000, 0, 0));
      vecs.push_back(mk(1, 1, 4'b0101, 4'b0001, 4'b0000, 0, 1));
      vecs.push_back(mk(1, 1, 4'b0101, 4'b0100, 4'b0100, 2, 2));
      vecs.push_back(mk(1, 1, 4'b0101, 4'b0001, 4'b0001, 0, 2));
      vecs.push_back(mk(1, 1, 4'b0000, 4'b0000, 4'b0100, 2, 2));
      vecs.push_back(mk(1, 1, 4'b0000, 4'b0000, 4'b0001, 0, 1));
      vecs.push_back(mk(1, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0));
      // dropped request leaves pointer at 1
      vecs.push_back(mk(1, 0, 4'b0010, 4'b0000, 4'b0000, 0, 0));
      vecs.push_back(mk(1, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0));
      vecs.push_back(mk(1, 1, 4'b0010, 4'b0010, 4'b0000, 0, 0));
      // reset mid-flight discards the entry, pointer back to 0
      vecs.push_back(mk(0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0));
      vecs.push_back(mk(1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0));
      vecs.push_back(mk(1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0));
      vecs.push_back(mk(1, 1, 4'b1111, 4'b0001, 4'b0000, 0, 0));
      vecs.push_back(mk(1, 1, 4'b0000, 4'b0000, 4'b0000, 0, 1));
      vecs.push_back(mk(1, 1, 4'b0000, 4'b0000, 4'b0001, 0, 1));
      vecs.push_back(mk(1, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0));

      foreach (vecs[i]) begin
         @(negedge clk);
         rst_a     = vecs[i].rst;
         bus_a.en  = vecs[i].en;
         bus_a.req = vecs[i].req;
         #2;
         chk($sformatf("v%0d_ack", i), int'(bus_a.ack), int'(vecs[i].ack));
         chk($sformatf("v%0d_gnt", i), int'(bus_a.gnt), int'(vecs[i].gnt));
         chk($sformatf("v%0d_gnt_vld", i), int'(bus_a.gnt_vld), int'(vecs[i].gnt != 4'b0000));
         chk($sformatf("v%0d_gnt_id", i), int'(bus_a.gnt_id), int'(vecs[i].gid));
         chk($sformatf("v%0d_out_cnt", i), int'(bus_a.out_cnt), int'(vecs[i].cnt));
         chk($sformatf("v%0d_busy", i), int'(bus_a.busy), int'(vecs[i].cnt != 2'd0));
      end

      // cap of one: accepts every other cycle
      exp_ab = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000};
      exp_gb = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000};
      @(negedge clk);
      rst_b = 1'b1;
      for (int t = 0; t < 8; t++) begin
         @(negedge clk);
         bus_b.en  = 1'b1;
         bus_b.req = 4'b1111;
         #2;
         chk($sformatf("cap1_t%0d_ack", t), int'(bus_b.ack), int'(exp_ab[t]));
         chk($sformatf("cap1_t%0d_gnt", t), int'(bus_b.gnt), int'(exp_gb[t]));
         chk($sformatf("cap1_t%0d_out_cnt", t), int'(bus_b.out_cnt), (t == 0) ? 0 : 1);
      end
      bus_b.en = 1'b0;

      // random traffic: every ack must reappear as the grant two cycles later
      ack_d1 = '0;
      ack_d2 = '0;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         bus_a.en  = 1'($urandom_range(0, 3) != 0);
         bus_a.req = 4'($urandom_range(0, 15));
         #2;
         chk("rnd_gnt", int'(bus_a.gnt), int'(ack_d2));
         chk("rnd_ack_onehot", int'($onehot0(bus_a.ack)), 1);
         chk("rnd_ack_in_req", int'(bus_a.ack & ~bus_a.req), 0);
         chk("rnd_out_cnt", int'(bus_a.out_cnt), int'(ack_d1 != 4'b0000) + int'(ack_d2 != 4'b0000));
         ack_d2 = ack_d1;
         ack_d1 = bus_a.ack;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
